// File: rtl/sr_cmd_pkg.sv
// Shared definitions for the SR command generator: FSM encoding and SR command codes.
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10
    } state_e;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_CLR  = 2'b01;

    function automatic logic [1:0] srForTarget(input logic target);
        return target ? SR_SET : SR_CLR;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// Button front end: 2-flop synchronizer, consecutive-high debounce counter and re-arm lock.
// Emits a single-cycle registered pulse per qualified press.
module sr_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic [7:0] dbCnt_q;
    logic [7:0] dbCnt_d;
    logic       locked_q;
    logic       locked_d;
    logic       press_q;
    logic       press_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // The lock holds off further pulses until the synchronized level has been seen low.
    always_comb begin
        dbCnt_d  = dbCnt_q;
        locked_d = locked_q;
        press_d  = 1'b0;
        if (!sync2_q) begin
            dbCnt_d  = 8'd0;
            locked_d = 1'b0;
        end else if (!locked_q) begin
            if (dbCnt_q == CNT_LAST) begin
                press_d  = 1'b1;
                locked_d = 1'b1;
                dbCnt_d  = 8'd0;
            end else begin
                dbCnt_d = dbCnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dbCnt_q  <= 8'd0;
            locked_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            dbCnt_q  <= dbCnt_d;
            locked_q <= locked_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns debounced set/clear button presses into one-cycle SR commands and confirms them
// against the flip-flop feedback, counting confirmed commands and flagging timeouts.
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned TMO_CYCLES = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       set_btn_i,
    input  logic       clr_btn_i,
    input  logic       q_fb_i,
    output logic [1:0] sr_o,
    output logic       busy_o,
    output logic       err_o,
    output logic [7:0] cmd_cnt_o
);

    localparam logic [3:0] TMO_LAST = 4'(TMO_CYCLES - 1);

    logic       setPress;
    logic       clrPress;

    state_e     state_q;
    state_e     state_d;
    logic       target_q;
    logic       target_d;
    logic [3:0] tmoCnt_q;
    logic [3:0] tmoCnt_d;
    logic [1:0] sr_q;
    logic [1:0] sr_d;
    logic       busy_q;
    logic       busy_d;
    logic       err_q;
    logic       err_d;
    logic [7:0] cmdCnt_q;
    logic [7:0] cmdCnt_d;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (set_btn_i),
        .press_o(setPress)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (clr_btn_i),
        .press_o(clrPress)
    );

    // Presses arriving outside IDLE, or both at once, are simply dropped.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        tmoCnt_d = tmoCnt_q;
        err_d    = err_q;
        cmdCnt_d = cmdCnt_q;
        case (state_q)
            IDLE: begin
                if (setPress ^ clrPress) begin
                    target_d = setPress;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                tmoCnt_d = 4'd0;
                state_d  = CHECK;
            end
            CHECK: begin
                if (q_fb_i == target_q) begin
                    cmdCnt_d = cmdCnt_q + 8'd1;
                    state_d  = IDLE;
                end else if (tmoCnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmoCnt_d = tmoCnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        sr_d   = (state_d == DRIVE) ? srForTarget(target_d) : SR_HOLD;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            target_q <= 1'b0;
            tmoCnt_q <= 4'd0;
            sr_q     <= SR_HOLD;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            cmdCnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            tmoCnt_q <= tmoCnt_d;
            sr_q     <= sr_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            cmdCnt_q <= cmdCnt_d;
        end
    end

    assign sr_o      = sr_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;
    assign cmd_cnt_o = cmdCnt_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed self-checking bench for sr_cmd_gen with a behavioural SR flip-flop on the feedback path.
module tb_sr_cmd_gen;

    logic       clk = 1'b0;
    logic       rstN;
    logic       setBtn;
    logic       clrBtn;
    logic       qFb;
    logic [1:0] sr;
    logic       busy;
    logic       err;
    logic [7:0] cmdCnt;

    logic fbReg    = 1'b0;
    logic tieHigh  = 1'b0;
    logic [1:0] prevSr = 2'b00;

    int assertCount = 0;
    int failCount   = 0;
    int setPulses   = 0;
    int setCycles   = 0;
    int clrPulses   = 0;
    int clrCycles   = 0;
    int sr11Count   = 0;
    int busyCycles  = 0;
    int savedInt;
    logic found;

    sr_cmd_gen #(.DB_CYCLES(4), .TMO_CYCLES(3)) dut (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .set_btn_i(setBtn),
        .clr_btn_i(clrBtn),
        .q_fb_i   (qFb),
        .sr_o     (sr),
        .busy_o   (busy),
        .err_o    (err),
        .cmd_cnt_o(cmdCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sr == 2'b10) fbReg <= 1'b1;
        else if (sr == 2'b01) fbReg <= 1'b0;
    end

    assign qFb = tieHigh ? 1'b1 : fbReg;

    always @(negedge clk) begin
        if (sr == 2'b10) begin
            setCycles++;
            if (prevSr != 2'b10) setPulses++;
        end
        if (sr == 2'b01) begin
            clrCycles++;
            if (prevSr != 2'b01) clrPulses++;
        end
        if (sr == 2'b11) sr11Count++;
        if (busy) busyCycles++;
        prevSr = sr;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called and returns at posedge+1; holds the buttons for holdCycles edges, then idles.
    task automatic applyStimulus(input logic s, input logic c, input int holdCycles, input int idleCycles);
        setBtn = s;
        clrBtn = c;
        repeat (holdCycles) @(posedge clk);
        #1;
        setBtn = 1'b0;
        clrBtn = 1'b0;
        repeat (idleCycles) @(posedge clk);
        #1;
    endtask

    task automatic waitForSr(input logic [1:0] value, input int maxCycles, output logic hit);
        hit = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(posedge clk);
            #1;
            if (sr == value) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulseReset();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN   = 1'b0;
        setBtn = 1'b0;
        clrBtn = 1'b0;
        #1;
        checkOutput("rst_sr", sr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_cnt", cmdCnt, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single set press: latency, one-cycle drive, confirmation in first CHECK cycle
        setBtn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("lat_early_sr", sr, 0);
        @(posedge clk);
        #1;
        checkOutput("lat_drive_sr", sr, 2);
        checkOutput("drive_busy", busy, 1);
        @(posedge clk);
        #1;
        checkOutput("check_sr", sr, 0);
        checkOutput("check_busy", busy, 1);
        @(posedge clk);
        #1;
        checkOutput("done_busy", busy, 0);
        checkOutput("done_cnt", cmdCnt, 1);
        applyStimulus(1'b1, 1'b0, 1, 6);
        checkOutput("set_pulses", setPulses, 1);
        checkOutput("set_width", setCycles, 1);
        checkOutput("set_err", err, 0);

        // Bouncing set never qualifies, stable hold then does
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 3, 1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("bounce_pulses", setPulses, 1);
        applyStimulus(1'b1, 1'b0, 6, 10);
        checkOutput("hold_pulses", setPulses, 2);
        checkOutput("hold_width", setCycles, 2);
        checkOutput("hold_cnt", cmdCnt, 2);

        // Simultaneous presses are discarded
        savedInt = busyCycles;
        applyStimulus(1'b1, 1'b1, 10, 8);
        checkOutput("both_setp", setPulses, 2);
        checkOutput("both_clrp", clrPulses, 0);
        checkOutput("both_busy", busyCycles - savedInt, 0);
        checkOutput("both_cnt", cmdCnt, 2);
        checkOutput("both_err", err, 0);

        // Clear against stuck-high feedback times out after 3 CHECK cycles
        tieHigh = 1'b1;
        clrBtn  = 1'b1;
        waitForSr(2'b01, 12, found);
        checkOutput("tmo_drive_seen", found, 1);
        clrBtn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("tmo_err_pre", err, 0);
        checkOutput("tmo_busy_pre", busy, 1);
        @(posedge clk);
        #1;
        checkOutput("tmo_err", err, 1);
        checkOutput("tmo_busy", busy, 0);
        checkOutput("tmo_cnt", cmdCnt, 2);
        checkOutput("tmo_clr_width", clrCycles, 1);
        applyStimulus(1'b1, 1'b0, 8, 6);
        checkOutput("after_tmo_cnt", cmdCnt, 3);
        checkOutput("after_tmo_err", err, 1);
        tieHigh = 1'b0;

        // Button held through reset qualifies once reset lifts
        rstN   = 1'b0;
        setBtn = 1'b1;
        #1;
        checkOutput("rst2_err", err, 0);
        checkOutput("rst2_cnt", cmdCnt, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        waitForSr(2'b10, 10, found);
        checkOutput("held_rst_drive", found, 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held_rst_cnt", cmdCnt, 1);
        applyStimulus(1'b0, 1'b0, 1, 4);

        // 256 alternating confirmed commands wrap the counter
        pulseReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(i[0], ~i[0], 8, 4);
            if (i == 254) checkOutput("cnt_255", cmdCnt, 255);
        end
        checkOutput("cnt_wrap", cmdCnt, 0);
        checkOutput("wrap_err", err, 0);
        checkOutput("sr11_never", sr11Count, 0);
        checkOutput("set_one_cycle", setCycles, setPulses);
        checkOutput("clr_one_cycle", clrCycles, clrPulses);

        // Reset during DRIVE aborts the command
        setBtn = 1'b1;
        waitForSr(2'b10, 12, found);
        checkOutput("abort_drive_seen", found, 1);
        setBtn = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("abort_sr", sr, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_cnt", cmdCnt, 0);
        savedInt = setPulses;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort_after_cnt", cmdCnt, 0);
        checkOutput("abort_after_busy", busy, 0);
        checkOutput("abort_after_pulses", setPulses, savedInt);
        checkOutput("abort_after_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive synchronized-high cycles needed to qualify a button press (range 1..255).
REQ-002 Parameter TMO_CYCLES, default 3: cycles allowed for q_fb to reach the commanded value after drive (range 1..15).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 set_btn  input  1  raw asynchronous set push-button, active-high.
REQ-006 clr_btn  input  1  raw asynchronous clear push-button, active-high.
REQ-007 q_fb  input  1  feedback from the downstream SR flip-flop q output.
REQ-008 sr  output  2  command to the SR flip-flop: sr[1]=S, sr[0]=R; 00 hold, 10 set, 01 clear.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 err  output  1  sticky feedback-timeout flag.
REQ-011 cmd_cnt  output  8  count of commands confirmed by feedback.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer before any other logic.
REQ-013 A press SHALL qualify once, on the cycle its synchronized level has been high for DB_CYCLES consecutive cycles; any low sample restarts the count.
REQ-014 A qualified button SHALL not qualify again until its synchronized level has been low for at least one cycle.
REQ-015 FSM states SHALL be IDLE, DRIVE, CHECK.
REQ-016 IDLE -> DRIVE on exactly one qualified press; target latched as 1 for set, 0 for clear.
REQ-017 Both buttons qualifying in the same cycle SHALL be discarded: no command issued, err unchanged, FSM stays IDLE.
REQ-018 DRIVE SHALL last exactly one cycle with sr=10 (target 1) or sr=01 (target 0), then go to CHECK.
REQ-019 sr SHALL be 00 in IDLE and CHECK, and 11 SHALL never be driven.
REQ-020 CHECK: if q_fb equals target, go to IDLE and increment cmd_cnt (255 wraps to 0) in that cycle.
REQ-021 CHECK: if q_fb differs for TMO_CYCLES consecutive cycles, set err, go to IDLE, leave cmd_cnt unchanged.
REQ-022 Presses qualifying while busy=1 SHALL be discarded; the re-arm rule (REQ-014) still applies.
REQ-023 A command whose target already equals q_fb SHALL still be driven and SHALL pass CHECK in its first cycle.
REQ-024 Min latency from synchronized button high to sr active = DB_CYCLES+1 cycles (+2 synchronizer cycles from raw input).
REQ-025 err SHALL clear only by reset.

Reset
REQ-026 On rst low, asynchronously: sr=00, busy=0, err=0, cmd_cnt=0, FSM=IDLE, synchronizers and debounce counters=0.
REQ-027 Reset asserted mid-DRIVE or mid-CHECK SHALL abort the command with no cmd_cnt or err update.
REQ-028 After rst deasserts, a button held high throughout reset SHALL qualify normally after 2+DB_CYCLES cycles.

Structure
REQ-029 Shared package sr_cmd_pkg SHALL hold the FSM state encoding and the sr constants SR_HOLD=00, SR_SET=10, SR_CLR=01.
REQ-030 Synchronizer, debounce counter and re-arm logic SHALL live in sub-module sr_debounce, instantiated once per button.
REQ-031 Outputs sr, busy, err and cmd_cnt SHALL be registered.

Verification
REQ-032 Reset, then set_btn high for 10 cycles with q_fb following sr[1] one cycle later -> one sr=10 pulse of one cycle, cmd_cnt=1, err=0.
REQ-033 set_btn bouncing (3 high, 1 low, repeated), DB_CYCLES=4 -> no sr pulse; then a stable 6-cycle hold -> exactly one sr=10 pulse.
REQ-034 set_btn and clr_btn raised on the same cycle for 10 cycles -> sr stays 00, busy stays 0, cmd_cnt unchanged.
REQ-035 clr_btn press with q_fb tied 1 -> sr=01 for one cycle, err=1 after 3 CHECK cycles, cmd_cnt unchanged; a later set press then succeeds and err stays 1.
REQ-036 256 confirmed commands with alternating set/clear -> cmd_cnt wraps to 0, and sr never equals 11.
REQ-037 rst pulled low in the DRIVE cycle -> sr=00 immediately, busy=0, cmd_cnt=0, and no command completes after release.
